// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : M-stage load/store sequencer. Issues word-aligned bus
//            transactions with byte strobes, stalls the pipeline until the
//            access completes and returns the extended load result.
//            Optional macro MISALIGNED_SPLIT_EN: perform misaligned accesses,
//            splitting word-crossing ones into two transactions.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [1:0]  mem_size_m,
  input  logic [2:0]  funct3_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        misalign_fault,
  output logic        bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
`ifdef MISALIGNED_SPLIT_EN
  localparam int unsigned STRB_W = 8;
`else
  localparam int unsigned STRB_W = 4;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ0 = 2'd1,
    S_REQ1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [29:0]         word_addr_q, word_addr_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [31:0]         lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         read_data_q, read_data_d;
  logic                fault_q, fault_d;
  logic                err_q, err_d;
  logic [31:0]         w_hi_word;
`ifdef MISALIGNED_SPLIT_EN
  logic [31:0]         hi_q, hi_d;
  assign w_hi_word = hi_q;
`else
  assign w_hi_word = 32'd0;
`endif

  logic        w_access;
  logic [1:0]  w_size;
  logic [3:0]  w_base;
  logic [31:0] w_wdata_rot;
  logic        w_timeout;
  logic        w_unused_funct3;

  assign w_access        = mem_read_m | mem_write_m;
  assign w_size          = (mem_size_m == 2'b11) ? 2'b10 : mem_size_m;
  assign w_timeout       = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  assign w_unused_funct3 = ^funct3_m[1:0];

`ifndef MISALIGNED_SPLIT_EN
  logic w_misaligned;
  assign w_misaligned = ((w_size == 2'b01) && alu_result_m[0]) ||
                        ((w_size == 2'b10) && (alu_result_m[1:0] != 2'b00));
`endif

  always_comb begin
    w_base = 4'b1111;
    case (w_size)
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
  end

  // Store data rotated so byte k lands on lane (k + offset) mod 4.
  always_comb begin
    w_wdata_rot = write_data_m;
    case (alu_result_m[1:0])
      2'd1:    w_wdata_rot = {write_data_m[23:0], write_data_m[31:24]};
      2'd2:    w_wdata_rot = {write_data_m[15:0], write_data_m[31:16]};
      2'd3:    w_wdata_rot = {write_data_m[7:0],  write_data_m[31:8]};
      default: w_wdata_rot = write_data_m;
    endcase
  end

  function automatic logic [31:0] load_extend(input logic [63:0] pair,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (size)
      2'b00:   load_extend = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'b01:   load_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    lo_d        = lo_q;
`ifdef MISALIGNED_SPLIT_EN
    hi_d        = hi_q;
`endif
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    fault_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_access) begin
          word_addr_d = alu_result_m[31:2];
          off_d       = alu_result_m[1:0];
          size_d      = w_size;
          uns_d       = funct3_m[2];
          we_d        = mem_write_m;
          wdata_d     = w_wdata_rot;
          strb_d      = STRB_W'({4'b0000, w_base} << alu_result_m[1:0]);
          lo_d        = 32'd0;
`ifdef MISALIGNED_SPLIT_EN
          hi_d        = 32'd0;
`endif
          cnt_d       = '0;
`ifndef MISALIGNED_SPLIT_EN
          if (w_misaligned) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            if (!mem_write_m) read_data_d = 32'd0;
          end else
`endif
          state_d = S_REQ0;
        end
      end
      S_REQ0: begin
        if (bus_ready) begin
          lo_d = bus_rdata;
`ifdef MISALIGNED_SPLIT_EN
          if (strb_q[7:4] != 4'b0000) begin
            state_d = S_REQ1;
            cnt_d   = '0;
          end else
`endif
          begin
            state_d = S_DONE;
            if (!we_q) read_data_d = load_extend({w_hi_word, bus_rdata}, off_q, size_q, uns_q);
          end
        end else if (w_timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!we_q) read_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      S_REQ1: begin
        if (bus_ready) begin
          hi_d    = bus_rdata;
          state_d = S_DONE;
          if (!we_q) read_data_d = load_extend({bus_rdata, lo_q}, off_q, size_q, uns_q);
        end else if (w_timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!we_q) read_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_addr_q <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      lo_q        <= '0;
`ifdef MISALIGNED_SPLIT_EN
      hi_q        <= '0;
`endif
      cnt_q       <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      lo_q        <= lo_d;
`ifdef MISALIGNED_SPLIT_EN
      hi_q        <= hi_d;
`endif
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      err_q       <= err_d;
    end
  end

  // Bus outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    bus_wstrb = 4'b0000;
    stall_m   = 1'b0;
    case (state_q)
      S_IDLE: stall_m = w_access;
      S_REQ0: begin
        stall_m   = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {word_addr_q, 2'b00};
        bus_wdata = we_q ? wdata_q : 32'd0;
        bus_wstrb = we_q ? strb_q[3:0] : 4'b0000;
      end
`ifdef MISALIGNED_SPLIT_EN
      S_REQ1: begin
        stall_m   = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {word_addr_q + 30'd1, 2'b00};
        bus_wdata = we_q ? wdata_q : 32'd0;
        bus_wstrb = we_q ? strb_q[7:4] : 4'b0000;
      end
`endif
      default: ;
    endcase
  end

  assign read_data_m    = read_data_q;
  assign misalign_fault = fault_q;
  assign bus_error      = err_q;

endmodule
`default_nettype wire
